seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand width in bits; legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, setting the iteration counter width.
REQ-003 sys_clk  input  1  the block's only clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request a multiply; sampled only while busy=0.
REQ-006 inputA  input  WIDTH  multiplicand.
REQ-007 inputB  input  WIDTH  multiplier.
REQ-008 busy  output  1  multiply in progress.
REQ-009 done  output  1  single-cycle pulse marking a new product.
REQ-010 product  output  2*WIDTH  registered result of the last completed multiply.
REQ-011 signed_mode  input  1  two's-complement select; present only when SEQ_MULT_SIGNED_EN is defined.

Function
REQ-012 The block SHALL be a shift-add multiplier with a three-state FSM: IDLE, RUN and FIN.
REQ-013 In IDLE with start=1, edge k SHALL latch inputA and inputB, clear the accumulator and the counter, set busy=1 and enter RUN.
REQ-014 Each RUN edge SHALL add the shifted multiplicand when the current multiplier LSB is 1, shift the operands, and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH edges, k+1..k+WIDTH, independent of operand values; zero operands get no early exit.
REQ-016 Edge k+WIDTH SHALL load product, set done=1, clear busy and enter FIN.
REQ-017 FIN SHALL last one cycle: done=1, busy=0. The next edge returns to IDLE and clears done.
REQ-018 start=1 during FIN SHALL be accepted as if in IDLE: it re-enters RUN and gives back-to-back operation with a period of WIDTH+1 cycles.
REQ-019 start, inputA and inputB changes while busy=1 SHALL be ignored; the latched operands are used.
REQ-020 product SHALL change only at the completion edge and SHALL hold its value until the next completion or reset.
REQ-021 Unsigned arithmetic SHALL be exact: product = inputA*inputB in 2*WIDTH bits, with no overflow possible.
REQ-022 busy and done SHALL never both be 1.

Reset
REQ-023 sys_rst=1 SHALL asynchronously force: state=IDLE, busy=0, done=0, product=0, accumulator=0, counter=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no product update.
REQ-025 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-026 With macro SEQ_MULT_SIGNED_EN defined, the signed_mode port SHALL exist and be latched with the operands at start.
REQ-027 With the macro defined and signed_mode=1, the operation SHALL be:
- operands treated as two's complement;
- magnitudes multiplied over WIDTH RUN edges;
- result negated at the completion edge when the operand signs differ.
REQ-028 Signed mode SHALL keep the same latency of WIDTH+1 edges; -2^(WIDTH-1) * -2^(WIDTH-1) SHALL yield +2^(2*WIDTH-2).
REQ-029 Without the macro, the signed_mode port SHALL be absent and all operation SHALL be unsigned, with no extra logic.

Verification
REQ-030 WIDTH=4, A=13, B=11, start at edge k -> busy high k..k+3, done high after k+4, product=143 (8'h8F).
REQ-031 WIDTH=4, A=0, B=9 -> product=0, done after k+4 (fixed latency); then A=15, B=15 -> 225 (8'hE1).
REQ-032 WIDTH=4, start pulsed again at k+2 with A=1, B=1 -> ignored, product=143; start during FIN with A=2, B=3 -> product=6 after five more edges.
REQ-033 WIDTH=4, sys_rst asserted at k+2 mid-RUN -> busy=0, done stays 0, product=0 immediately (asynchronous reset).
REQ-034 SEQ_MULT_SIGNED_EN, WIDTH=4, signed_mode=1: A=4'hD (-3), B=5 -> 8'hF1 (-15); A=4'h8, B=4'h8 -> 8'h40 (+64).
REQ-035 WIDTH=8, A=255, B=255 -> product=16'hFE01, done after k+8.

Source files
------------

// File: rtl/seq_mult.sv
// Shift-add sequential multiplier: IDLE -> RUN (WIDTH edges) -> FIN.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port (two's-complement operands).
module seq_mult #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   inputA,
   input  logic [WIDTH-1:0]   inputB,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic               signed_mode,
`endif
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [PW-1:0]    sum;
   logic [WIDTH-1:0] a_mag, b_mag;
`ifdef SEQ_MULT_SIGNED_EN
   logic             neg_q, neg_d;
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_MULT_SIGNED_EN
      neg_d = neg_q;
      // Signed operands run through the datapath as magnitudes
      a_mag = (signed_mode && inputA[WIDTH-1]) ? -inputA : inputA;
      b_mag = (signed_mode && inputB[WIDTH-1]) ? -inputB : inputB;
`else
      a_mag = inputA;
      b_mag = inputB;
`endif
      unique case (state_q)
         IDLE, FIN: begin
            state_d = IDLE;
            if (start) begin
               state_d  = RUN;
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
               neg_d = signed_mode & (inputA[WIDTH-1] ^ inputB[WIDTH-1]);
`endif
            end
         end
         RUN: begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIN;
`ifdef SEQ_MULT_SIGNED_EN
               prod_d = neg_q ? -sum : sum;
`else
               prod_d = sum;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
`ifdef SEQ_MULT_SIGNED_EN
         neg_q    <= neg_d;
`endif
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == FIN);
   assign product = prod_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: WIDTH=4 and WIDTH=8 instances.
// Vector table, random ops against an arithmetic model, corner sequences.
module tb_seq_mult;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic       sm = 1'b0;
   logic       busy, done;
   logic [7:0] product;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] product8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mult #(.WIDTH(4)) dut (
      .sys_clk(clk), .sys_rst(rst), .start(start),
      .inputA(a), .inputB(b),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(sm),
`endif
      .busy(busy), .done(done), .product(product)
   );

   seq_mult #(.WIDTH(8)) dut8 (
      .sys_clk(clk), .sys_rst(rst), .start(start8),
      .inputA(a8), .inputB(b8),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(1'b0),
`endif
      .busy(busy8), .done(done8), .product(product8)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && busy && done) begin
         errors++;
         $display("FAIL busy_done_overlap actual=1 required=0");
      end
   end

   function automatic logic [7:0] ref4(input int x, input int y, input bit s);
      int p, q;
      p = x;
      q = y;
      if (s) begin
         if (p >= 8) p -= 16;
         if (q >= 8) q -= 16;
      end
      return 8'(p * q);
   endfunction

   task automatic mul4(input logic [3:0] x, input logic [3:0] y,
                       input logic s, input logic [7:0] exp,
                       input string name);
      int n;
      @(negedge clk);
      start = 1'b1; a = x; b = y; sm = s;
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, "_busy"}, busy, 1);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_lat"}, n, 4);
      chk({name, "_prod"}, product, exp);
      a = ~x; b = ~y;
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_hold"}, product, exp);
   endtask

   task automatic mul8(input logic [7:0] x, input logic [7:0] y,
                       input string name);
      int n;
      logic [15:0] exp;
      exp = 16'(int'(x) * int'(y));
      @(negedge clk);
      start8 = 1'b1; a8 = x; b8 = y;
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_lat"}, n, 8);
      chk({name, "_prod"}, product8, exp);
   endtask

   initial begin
      vec_t vecs[7];
      int n, m;
      bit seen;
      logic [3:0] ra, rb;
      logic rs;

      vecs[0] = '{4'd13, 4'd11, 8'h8F};
      vecs[1] = '{4'd0,  4'd9,  8'h00};
      vecs[2] = '{4'd15, 4'd15, 8'hE1};
      vecs[3] = '{4'd1,  4'd1,  8'h01};
      vecs[4] = '{4'd2,  4'd3,  8'h06};
      vecs[5] = '{4'd15, 4'd0,  8'h00};
      vecs[6] = '{4'd8,  4'd2,  8'h10};

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_prod", product, 0);
      chk("rst_prod8", product8, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         mul4(vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));

      for (int i = 0; i < 30; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rs = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`endif
         mul4(ra, rb, rs, ref4(int'(ra), int'(rb), rs), $sformatf("rnd%0d", i));
      end

      // start/operand changes mid-run are ignored, then start during FIN
      @(negedge clk);
      start = 1'b1; a = 4'd13; b = 4'd11;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; a = 4'd1; b = 4'd1;
      @(posedge clk); #1;
      start = 1'b0; a = 4'd0; b = 4'd0;
      n = 2;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ign_lat", n, 4);
      chk("ign_prod", product, 8'h8F);
      start = 1'b1; a = 4'd2; b = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_done", done, 0);
      m = 1;
      while (done !== 1'b1 && m < 40) begin
         @(posedge clk); #1;
         m++;
      end
      chk("b2b_lat", m, 5);
      chk("b2b_prod", product, 8'h06);
      @(posedge clk); #1;
      chk("fin_clear", done, 0);

      // asynchronous reset mid-run
      @(negedge clk);
      start = 1'b1; a = 4'd15; b = 4'd15;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_prod", product, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("arst_nodone", seen, 0);
      chk("arst_prod_hold", product, 0);
      mul4(4'd5, 4'd7, 1'b0, 8'd35, "post_rst");

`ifdef SEQ_MULT_SIGNED_EN
      mul4(4'hD, 4'd5, 1'b1, 8'hF1, "sgn_m3x5");
      mul4(4'h8, 4'h8, 1'b1, 8'h40, "sgn_min");
      mul4(4'h7, 4'h8, 1'b1, 8'hC8, "sgn_7xm8");
      mul4(4'hD, 4'd5, 1'b0, 8'h41, "usgn_13x5");
`endif

      mul8(8'd255, 8'd255, "w8_max");
      mul8(8'd0, 8'd200, "w8_zero");
      for (int i = 0; i < 8; i++)
         mul8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              $sformatf("w8_rnd%0d", i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
